// File: rtl/cam_pkg.sv
// Shared definitions for the DVP capture path.
//   cam_state_e : capture FSM encoding (IDLE / ARM / CAPT)
//   PIX_W       : RGB565 pixel width
//   cam_entry_t : pixel FIFO entry layout {sof, eol, data}
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_CAPT = 2'd2
    } cam_state_e;

    localparam int PIX_W = 16;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] data;
    } cam_entry_t;

    localparam int ENTRY_W = $bits(cam_entry_t);

endpackage

// File: rtl/cam_pix_fifo.sv
// Synchronous single-clock pixel FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write request and entry; ignored when full unless popping
//   pop        : read request; ignored when empty
//   dout       : head entry, held stable until popped
//   empty/full : occupancy flags
module cam_pix_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/camera_capture.sv
// DVP pixel capture: oversamples an OV-style camera bus on CLK, pairs bytes
// into RGB565 pixels tagged with SOF/EOL, buffers them and streams them out.
//   CLK, RESETn                    : system clock (>=4x CAM_PCLK), async active-low reset
//   CAM_PCLK/VSYNC/HREF/D          : raw camera inputs, treated as asynchronous data
//   EN, MODE_SINGLE, START         : capture enable, single-frame mode, single-frame arm pulse
//   CLR_STATUS                     : clears OVERFLOW and LINE_ERR
//   PIX_VALID/READY/DATA/SOF/EOL   : pixel stream
//   BUSY, FRAME_CNT                : FSM not idle, completed frame count
//   OVERFLOW, LINE_ERR             : sticky error flags
module camera_capture
    import cam_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int VSYNC_POL   = 1
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        CAM_PCLK,
    input  logic        CAM_VSYNC,
    input  logic        CAM_HREF,
    input  logic [7:0]  CAM_D,
    input  logic        EN,
    input  logic        MODE_SINGLE,
    input  logic        START,
    input  logic        CLR_STATUS,
    output logic        PIX_VALID,
    input  logic        PIX_READY,
    output logic [15:0] PIX_DATA,
    output logic        PIX_SOF,
    output logic        PIX_EOL,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT,
    output logic        OVERFLOW,
    output logic        LINE_ERR
);

    localparam int XW = $clog2(IMG_W + 2);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H);
    localparam logic          VPOL   = 1'(VSYNC_POL);

    logic [SYNC_STAGES-1:0] pclk_sync, href_sync, vs_sync;
    logic [7:0]             d_sync [SYNC_STAGES];
    logic [SYNC_STAGES:0]   prime;
    logic                   pclk_d, href_d, vs_d;
    logic                   pclk_s, href_s, vs_s, primed;
    logic [7:0]             d_s;
    logic                   pclk_rise, href_fall, vs_leave, vs_enter;

    cam_state_e             state_q, state_d;
    logic                   clr_pos, frame_done, capt;

    logic                   phase;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [7:0]             hi_byte;
    logic                   in_window, byte_ev, line_err_set, ovf_set;

    logic                   vld_p0;
    cam_entry_t             ent_p0;

    logic [ENTRY_W-1:0]     fifo_dout;
    logic                   fifo_empty, fifo_full, fifo_pop;
    cam_entry_t             head;

    // ---- input synchronizers ----
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pclk_sync <= '0;
            href_sync <= '0;
            vs_sync   <= '0;
            prime     <= '0;
            pclk_d    <= 1'b0;
            href_d    <= 1'b0;
            vs_d      <= 1'b0;
        end else begin
            pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], CAM_PCLK};
            href_sync <= {href_sync[SYNC_STAGES-2:0], CAM_HREF};
            vs_sync   <= {vs_sync[SYNC_STAGES-2:0], CAM_VSYNC};
            prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
            pclk_d    <= pclk_s;
            href_d    <= href_s;
            vs_d      <= vs_s;
        end
    end

    always_ff @(posedge CLK) begin
        d_sync[0] <= CAM_D;
        for (int i = 1; i < SYNC_STAGES; i++) d_sync[i] <= d_sync[i-1];
    end

    assign pclk_s = pclk_sync[SYNC_STAGES-1];
    assign href_s = href_sync[SYNC_STAGES-1];
    assign vs_s   = vs_sync[SYNC_STAGES-1];
    assign d_s    = d_sync[SYNC_STAGES-1];

    // Edges are masked until the synchronizer and delay flops hold real samples,
    // so the reset value cannot masquerade as a VSYNC/HREF transition.
    assign primed    = prime[SYNC_STAGES];
    assign pclk_rise = primed & pclk_s & ~pclk_d;
    assign href_fall = primed & href_d & ~href_s;
    assign vs_leave  = primed & (vs_d == VPOL) & (vs_s != VPOL);
    assign vs_enter  = primed & (vs_d != VPOL) & (vs_s == VPOL);

    // ---- capture FSM ----
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        clr_pos    = 1'b0;
        frame_done = 1'b0;
        if (!EN) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (!MODE_SINGLE || START) state_d = ST_ARM;
                ST_ARM: if (vs_leave) begin
                    state_d = ST_CAPT;
                    clr_pos = 1'b1;
                end
                ST_CAPT: if (vs_enter) begin
                    frame_done = 1'b1;
                    state_d    = MODE_SINGLE ? ST_IDLE : ST_ARM;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign capt = (state_q == ST_CAPT) & EN;
    assign BUSY = (state_q != ST_IDLE);

    // ---- byte pairing ----
    assign in_window    = (x < X_MAX) & (y < Y_MAX);
    assign byte_ev      = capt & pclk_rise & href_s;
    assign line_err_set = (capt & href_fall & (phase | (x != X_MAX)))
                        | (byte_ev & phase & ~in_window);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            phase  <= 1'b0;
            x      <= '0;
            y      <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (clr_pos) begin
                phase <= 1'b0;
                x     <= '0;
                y     <= '0;
            end else if (!capt) begin
                // Leaving capture discards any half-assembled pixel.
                phase <= 1'b0;
            end else if (href_fall) begin
                phase <= 1'b0;
                x     <= '0;
                if (y < Y_MAX) y <= y + 1'b1;
            end else if (byte_ev) begin
                phase <= ~phase;
                if (phase) begin
                    // x stops one past IMG_W so an over-long line still reads as wrong length.
                    if (x <= X_MAX) x <= x + 1'b1;
                    vld_p0 <= in_window;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (byte_ev) begin
            if (!phase) begin
                hi_byte <= d_s;
            end else begin
                ent_p0.sof  <= (x == '0) && (y == '0);
                ent_p0.eol  <= (x == X_LAST);
                ent_p0.data <= {hi_byte, d_s};
            end
        end
    end

    // ---- pixel FIFO ----
    assign fifo_pop = PIX_VALID & PIX_READY;
    assign ovf_set  = vld_p0 & fifo_full & ~fifo_pop;

    cam_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESETn),
        .push  (vld_p0),
        .din   (ent_p0),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Storage is not reset, so the stream fields are forced to zero while empty.
    assign head      = cam_entry_t'(fifo_dout);
    assign PIX_VALID = ~fifo_empty;
    assign PIX_DATA  = fifo_empty ? '0   : head.data;
    assign PIX_SOF   = fifo_empty ? 1'b0 : head.sof;
    assign PIX_EOL   = fifo_empty ? 1'b0 : head.eol;

    // ---- status ----
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            FRAME_CNT <= '0;
            OVERFLOW  <= 1'b0;
            LINE_ERR  <= 1'b0;
        end else begin
            if (frame_done) FRAME_CNT <= FRAME_CNT + 1'b1;
            if (ovf_set)         OVERFLOW <= 1'b1;
            else if (CLR_STATUS) OVERFLOW <= 1'b0;
            if (line_err_set)    LINE_ERR <= 1'b1;
            else if (CLR_STATUS) LINE_ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture with a 4x2 image and a 4-deep FIFO.
module tb_camera_capture;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        CAM_PCLK = 1'b0;
    logic        CAM_VSYNC = 1'b1;
    logic        CAM_HREF = 1'b0;
    logic [7:0]  CAM_D = 8'h00;
    logic        EN = 1'b0;
    logic        MODE_SINGLE = 1'b0;
    logic        START = 1'b0;
    logic        CLR_STATUS = 1'b0;
    logic        PIX_VALID;
    logic        PIX_READY = 1'b1;
    logic [15:0] PIX_DATA;
    logic        PIX_SOF;
    logic        PIX_EOL;
    logic        BUSY;
    logic [15:0] FRAME_CNT;
    logic        OVERFLOW;
    logic        LINE_ERR;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    logic [17:0] q[$];
    logic [7:0]  bval;
    bit          m_cap = 0;
    int          mx, my;
    int          m_left = -1;

    camera_capture #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(4), .SYNC_STAGES(2), .VSYNC_POL(1)
    ) dut (
        .CLK(CLK), .RESETn(RESETn), .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC),
        .CAM_HREF(CAM_HREF), .CAM_D(CAM_D), .EN(EN), .MODE_SINGLE(MODE_SINGLE),
        .START(START), .CLR_STATUS(CLR_STATUS), .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY), .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF),
        .PIX_EOL(PIX_EOL), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT),
        .OVERFLOW(OVERFLOW), .LINE_ERR(LINE_ERR)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: each handshake pops the oldest expected entry.
    always @(negedge CLK) begin
        if (RESETn && PIX_VALID && PIX_READY) begin
            logic [17:0] exp_e;
            checks++;
            n_out++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel got=%h expected=none", {PIX_SOF, PIX_EOL, PIX_DATA});
            end else begin
                exp_e = q.pop_front();
                if ({PIX_SOF, PIX_EOL, PIX_DATA} !== exp_e) begin
                    errors++;
                    $display("FAIL pixel got=%h expected=%h", {PIX_SOF, PIX_EOL, PIX_DATA}, exp_e);
                end
            end
        end
    end

    task automatic next_byte(output logic [7:0] b);
        b = bval;
        bval = bval + 8'h22;
    endtask

    task automatic cam_byte(input logic [7:0] b);
        CAM_D = b;
        #40 CAM_PCLK = 1'b1;
        #40 CAM_PCLK = 1'b0;
    endtask

    task automatic send_line(input int npix, input bit extra);
        logic [7:0] hi, lo;
        CAM_HREF = 1'b1;
        #40;
        for (int i = 0; i < npix; i++) begin
            next_byte(hi);
            next_byte(lo);
            if (m_cap && mx < IMG_W && my < IMG_H && m_left != 0) begin
                q.push_back({(mx == 0 && my == 0), (mx == IMG_W - 1), hi, lo});
                if (m_left > 0) m_left--;
            end
            mx++;
            cam_byte(hi);
            cam_byte(lo);
        end
        if (extra) begin
            next_byte(hi);
            cam_byte(hi);
        end
        CAM_HREF = 1'b0;
        #80;
        mx = 0;
        my++;
    endtask

    task automatic frame_begin(input bit cap);
        CAM_VSYNC = 1'b0;
        #80;
        m_cap = cap;
        mx = 0;
        my = 0;
    endtask

    task automatic frame_end();
        CAM_VSYNC = 1'b1;
        #160;
        m_cap = 0;
    endtask

    task automatic send_frame(input bit cap);
        frame_begin(cap);
        send_line(IMG_W, 0);
        send_line(IMG_W, 0);
        frame_end();
    endtask

    task automatic pulse_clr();
        @(negedge CLK) CLR_STATUS = 1'b1;
        @(negedge CLK) CLR_STATUS = 1'b0;
        @(negedge CLK);
    endtask

    task automatic set_ready(input logic v);
        @(posedge CLK);
        #1 PIX_READY = v;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESETn = 1'b0;
        EN = 1'b0;
        MODE_SINGLE = 1'b0;
        START = 1'b0;
        CLR_STATUS = 1'b0;
        CAM_VSYNC = 1'b1;
        CAM_HREF = 1'b0;
        CAM_PCLK = 1'b0;
        q.delete();
        m_cap = 0;
        m_left = -1;
        bval = 8'h12;
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        n_out = 0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge CLK);
        repeat (20) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required=0", name, q.size());
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({PIX_VALID, PIX_SOF, PIX_EOL, BUSY, OVERFLOW, LINE_ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000000",
                     {PIX_VALID, PIX_SOF, PIX_EOL, BUSY, OVERFLOW, LINE_ERR});
        end
        checks++;
        if ({PIX_DATA, FRAME_CNT} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data data=%h frame_cnt=%h required=0", PIX_DATA, FRAME_CNT);
        end
    endtask

    task automatic test_continuous();
        do_reset();
        EN = 1'b1;
        repeat (4) @(negedge CLK);
        send_frame(1);
        wait_drain("continuous");
        checks++;
        if (n_out !== 8) begin errors++; $display("FAIL cont_count got=%0d required=8", n_out); end
        checks++;
        if (FRAME_CNT !== 16'd1) begin errors++; $display("FAIL cont_frame_cnt got=%0d required=1", FRAME_CNT); end
        checks++;
        if ({OVERFLOW, LINE_ERR} !== 2'b00) begin
            errors++;
            $display("FAIL cont_status got=%b required=00", {OVERFLOW, LINE_ERR});
        end
    endtask

    task automatic test_single();
        do_reset();
        MODE_SINGLE = 1'b1;
        EN = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_prestart got=%b required=0", BUSY); end
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_armed got=%b required=1", BUSY); end
        send_frame(1);
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b required=0", BUSY); end
        send_frame(0);
        send_frame(0);
        wait_drain("single");
        checks++;
        if (n_out !== 8) begin errors++; $display("FAIL single_count got=%0d required=8", n_out); end
        checks++;
        if (FRAME_CNT !== 16'd1) begin errors++; $display("FAIL single_frame_cnt got=%0d required=1", FRAME_CNT); end
    endtask

    task automatic test_backpressure();
        logic [17:0] h;
        do_reset();
        set_ready(1'b0);
        EN = 1'b1;
        repeat (4) @(negedge CLK);
        m_left = 4;
        frame_begin(1);
        send_line(IMG_W, 0);
        h = q[0];
        checks++;
        if ({PIX_VALID, PIX_SOF, PIX_DATA} !== {1'b1, h[17], h[15:0]}) begin
            errors++;
            $display("FAIL bp_head_line0 got=%b/%b/%h required=1/%b/%h", PIX_VALID, PIX_SOF, PIX_DATA, h[17], h[15:0]);
        end
        checks++;
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL bp_ovf_at_full got=%b required=0", OVERFLOW); end
        send_line(IMG_W, 0);
        frame_end();
        checks++;
        if ({PIX_VALID, PIX_SOF, PIX_DATA} !== {1'b1, h[17], h[15:0]}) begin
            errors++;
            $display("FAIL bp_head_stable got=%b/%b/%h required=1/%b/%h", PIX_VALID, PIX_SOF, PIX_DATA, h[17], h[15:0]);
        end
        checks++;
        if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL bp_ovf_set got=%b required=1", OVERFLOW); end
        pulse_clr();
        checks++;
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr got=%b required=0", OVERFLOW); end
        set_ready(1'b1);
        wait_drain("backpressure");
        checks++;
        if (n_out !== 4) begin errors++; $display("FAIL bp_count got=%0d required=4", n_out); end
        checks++;
        if (LINE_ERR !== 1'b0) begin errors++; $display("FAIL bp_line_err got=%b required=0", LINE_ERR); end
        m_left = -1;
    endtask

    task automatic test_line_err();
        do_reset();
        EN = 1'b1;
        repeat (4) @(negedge CLK);
        frame_begin(1);
        send_line(5, 0);
        checks++;
        if (LINE_ERR !== 1'b1) begin errors++; $display("FAIL lerr_long got=%b required=1", LINE_ERR); end
        pulse_clr();
        checks++;
        if (LINE_ERR !== 1'b0) begin errors++; $display("FAIL lerr_clr got=%b required=0", LINE_ERR); end
        send_line(IMG_W, 1);
        checks++;
        if (LINE_ERR !== 1'b1) begin errors++; $display("FAIL lerr_odd got=%b required=1", LINE_ERR); end
        pulse_clr();
        send_line(IMG_W, 0);
        checks++;
        if (LINE_ERR !== 1'b1) begin errors++; $display("FAIL lerr_extra_line got=%b required=1", LINE_ERR); end
        frame_end();
        wait_drain("line_err");
        checks++;
        if (n_out !== 8) begin errors++; $display("FAIL lerr_count got=%0d required=8", n_out); end
    endtask

    task automatic test_en_drop();
        logic [7:0] b;
        do_reset();
        EN = 1'b1;
        repeat (4) @(negedge CLK);
        frame_begin(0);
        CAM_HREF = 1'b1;
        #40;
        next_byte(b);
        cam_byte(b);
        EN = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL endrop_busy got=%b required=0", BUSY); end
        EN = 1'b1;
        next_byte(b);
        cam_byte(b);
        CAM_HREF = 1'b0;
        #80;
        send_line(IMG_W, 0);
        frame_end();
        checks++;
        if (PIX_VALID !== 1'b0) begin errors++; $display("FAIL endrop_no_partial got=%b required=0", PIX_VALID); end
        send_frame(1);
        wait_drain("en_drop");
        checks++;
        if (FRAME_CNT !== 16'd1) begin errors++; $display("FAIL endrop_frame_cnt got=%0d required=1", FRAME_CNT); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        set_ready(1'b0);
        EN = 1'b1;
        repeat (4) @(negedge CLK);
        frame_begin(1);
        send_line(IMG_W, 0);
        checks++;
        if (PIX_VALID !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b required=1", PIX_VALID); end
        @(negedge CLK) RESETn = 1'b0;
        #1;
        checks++;
        if ({PIX_VALID, PIX_SOF, PIX_EOL, BUSY, PIX_DATA} !== 20'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%b/%b/%b/%b/%h required=0",
                     PIX_VALID, PIX_SOF, PIX_EOL, BUSY, PIX_DATA);
        end
        q.delete();
        m_cap = 0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        n_out = 0;
        send_line(IMG_W, 0);
        frame_end();
        set_ready(1'b1);
        send_frame(1);
        wait_drain("reset_mid");
        checks++;
        if (n_out !== 8) begin errors++; $display("FAIL rstmid_count got=%0d required=8", n_out); end
    endtask

    initial begin
        bval = 8'h12;
        test_reset();
        test_continuous();
        test_single();
        test_backpressure();
        test_line_err();
        test_en_drop();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached required=finish");
        $fatal(1, "timeout");
    end

endmodule
